// File: rtl/odd_even_pkg.sv
// Shared types and helpers for the odd/even merge path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: turn enum, parity check helper, FIFO depth legality check.
package odd_even_pkg;

  // Which class the output should take next.
  typedef enum logic {
    TURN_EVEN = 1'b0,
    TURN_ODD  = 1'b1
  } turn_e;

  // Smallest legal class FIFO depth.
  localparam int unsigned MIN_DEPTH = 2;

  // A word belongs to the odd class exactly when its LSB is set.
  function automatic logic parity_ok(input logic lsb, input logic is_odd_class);
    return lsb == is_odd_class;
  endfunction

  // Depth must be a power of two so the pointers can wrap naturally.
  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/merge_fifo.sv
// Per-class buffer: synchronous-write FIFO with a combinational head word.
// Latency: a word pushed at edge N is visible on dout after edge N.
// Backpressure: full is registered; pushes while full and pops while empty are ignored.
// Ports: clk, reset (async active-low), push/din, pop/dout, full, empty.
module merge_fifo
  import odd_even_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("merge_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/odd_even_merge.sv
// Merges parity-split odd/even streams into one alternating, registered output stream.
// Latency: input handshake at edge N can be presented on out_* after edge N+1.
// Backpressure: per-class ready = enable && !full; output holds while out_valid && !out_ready.
// Ports: clk, reset (async active-low), enable, strict, odd_*/even_* inputs with ready,
//        out_valid/out_ready/out_data/out_is_odd, parity_err (one-cycle pulse on dropped word).
module odd_even_merge
  import odd_even_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             strict,
  input  logic             odd_valid,
  output logic             odd_ready,
  input  logic [WIDTH-1:0] odd_in,
  input  logic             even_valid,
  output logic             even_ready,
  input  logic [WIDTH-1:0] even_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_is_odd,
  output logic             parity_err
);

  logic             odd_full, odd_empty, even_full, even_empty;
  logic [WIDTH-1:0] odd_dout, even_dout;
  logic             odd_hs, even_hs;
  logic             odd_push, even_push;
  logic             pop_odd, pop_even;
  logic             load;

  turn_e            turn_q, turn_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_is_odd_q, out_is_odd_d;
  logic             parity_err_q, parity_err_d;

  // Ready comes only from registered occupancy, so a same-cycle pop never reopens a full FIFO.
  assign odd_ready  = enable && !odd_full;
  assign even_ready = enable && !even_full;

  assign odd_hs    = odd_valid && odd_ready;
  assign even_hs   = even_valid && even_ready;
  assign odd_push  = odd_hs && parity_ok(odd_in[0], 1'b1);
  assign even_push = even_hs && parity_ok(even_in[0], 1'b0);

  assign load = enable && (!out_valid_q || out_ready);

  merge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_odd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (odd_push),
    .pop   (pop_odd),
    .din   (odd_in),
    .dout  (odd_dout),
    .full  (odd_full),
    .empty (odd_empty)
  );

  merge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_even_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (even_push),
    .pop   (pop_even),
    .din   (even_in),
    .dout  (even_dout),
    .full  (even_full),
    .empty (even_empty)
  );

  always_comb begin
    pop_odd      = 1'b0;
    pop_even     = 1'b0;
    turn_d       = turn_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_is_odd_d = out_is_odd_q;

    // Turn class first; in non-strict mode the other class fills an empty turn.
    if (load) begin
      if (turn_q == TURN_ODD) begin
        if (!odd_empty)                 pop_odd  = 1'b1;
        else if (!strict && !even_empty) pop_even = 1'b1;
      end else begin
        if (!even_empty)                pop_even = 1'b1;
        else if (!strict && !odd_empty)  pop_odd  = 1'b1;
      end
    end

    if (pop_odd || pop_even) begin
      out_valid_d  = 1'b1;
      out_is_odd_d = pop_odd;
      out_data_d   = pop_odd ? odd_dout : even_dout;
      turn_d       = pop_odd ? TURN_EVEN : TURN_ODD;
    end else if (out_valid_q && out_ready) begin
      // Consumed with nothing to replace it; also lets a handshake finish while disabled.
      out_valid_d = 1'b0;
    end

    parity_err_d = (odd_hs && !parity_ok(odd_in[0], 1'b1)) ||
                   (even_hs && !parity_ok(even_in[0], 1'b0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_q       <= TURN_ODD;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_is_odd_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      turn_q       <= turn_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_is_odd_q <= out_is_odd_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_is_odd = out_is_odd_q;
  assign parity_err = parity_err_q;

endmodule
